scr1_tb_ahb_dmem_monitor: RTL
=============================

# scr1_tb_ahb_dmem_monitor

Passive AHB-Lite snooper on the testbench data-memory bus, between the core's dmem master port and the AHB memory model. Tracks address/data-phase pipelining and counts completed reads, writes and error responses. Detects a test-completion write to a host-communication address and reports done/pass/code to the run-tests logic. Also provides a watchdog that ends a run with no completed transfers.

## Interface
Parameters:
- TOHOST_ADDR, 32'h0000_F000, word address whose write signals test completion
- WDOG_CYCLES, 2_000_000, cycles without a completed transfer before timeout (≥2)

Ports:
- clk  in  1  bus clock
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- dmem_htrans  in  2  AHB transfer type
- dmem_haddr  in  SCR1_AHB_WIDTH  address
- dmem_hwrite  in  1  write when 1
- dmem_hsize  in  3  transfer size
- dmem_hwdata  in  SCR1_AHB_WIDTH  write data (data phase)
- dmem_hready  in  1  slave ready
- dmem_hresp  in  1  SCR1_HRESP_ERR=1
- test_done  out  1  sticky; completion write or timeout seen
- test_pass  out  1  sticky; valid with test_done
- test_timeout  out  1  sticky; watchdog expired
- test_code  out  31  failure code (tohost value >> 1)
- cycle_cnt  out  32  cycles spent in RUN
- rd_cnt / wr_cnt / err_cnt  out  32 each  completed reads, writes, ERROR responses
- proto_err  out  1  sticky protocol violation (see Configuration)

## Operation
- Address phase accepted when dmem_hready=1 and dmem_htrans ∈ {NONSEQ 2'b10, SEQ 2'b11}; register ap_valid, ap_addr, ap_write, ap_size. IDLE/BUSY with hready=1 clear ap_valid.
- Data phase completes on first cycle with ap_valid=1 and dmem_hready=1. On completion: hresp=ERR → err_cnt+1 (not rd/wr); else ap_write ? wr_cnt+1 : rd_cnt+1.
- Pipelining: new address phase accepted in the same hready cycle that completes the previous data phase; both update at that edge.
- Completion write: OK write, ap_addr[31:2]==TOHOST_ADDR[31:2], ap_size=3'b010, dmem_hwdata[0]=1. Value 1 → pass; else fail, test_code=hwdata[31:1]. Other sizes or hwdata[0]=0 to TOHOST: counted as ordinary writes only.
- FSM: RUN (reset state) → DONE on completion write; RUN → TMO when watchdog reaches WDOG_CYCLES-1 and no completion that cycle. DONE/TMO absorbing until rst_n. Completion and watchdog expiry in same cycle → DONE.
- In TMO: test_done=1, test_timeout=1, test_pass=0, test_code=0.
- Counters increment only in RUN, saturate at 32'hFFFF_FFFF; frozen in DONE/TMO. Watchdog clears on every completed data phase (any response).

## Timing
- Reset: every output 0, FSM=RUN, ap_valid=0, watchdog=0.
- test_done/test_pass/test_code/counters registered: visible one clk after the completing hready edge.
- cycle_cnt increments every clk in RUN, including the cycle in which DONE is entered; first value 1 one clk after reset release.
- Reset mid-transfer: pending address phase dropped, no count.
- Monitor drives no bus signal; zero impact on bus timing.

## Configuration
- SCR1_TB_AHB_MON_PROTOCHK_EN defined: proto_err set (sticky) on: (a) htrans or haddr changed while a NONSEQ/SEQ is held with hready=0; (b) accepted address misaligned for hsize (halfword addr[0]≠0, word addr[1:0]≠0); (c) hsize > 3'b010. Also $error message in simulation.
- Not defined: proto_err tied 0, checker logic absent.

## Test plan
- Reset, then 3 word reads and 2 writes at 0x200, no wait states → rd_cnt=3, wr_cnt=2, test_done=0.
- Write 32'h1 to 0xF000 with 2 wait states → test_done=1, test_pass=1 one clk after data-phase hready; counters frozen.
- Write 32'h0000_0007 to 0xF000 → test_done=1, test_pass=0, test_code=3.
- Read with ERROR response (hready low 1 cycle, then high with hresp=1) → err_cnt=1, rd_cnt unchanged.
- WDOG_CYCLES=16, no transfers → test_timeout=1, test_done=1 at cycle 16; write to TOHOST afterwards ignored.
- With SCR1_TB_AHB_MON_PROTOCHK_EN: word NONSEQ at 0x202 → proto_err=1; without macro → proto_err=0.

Source files
------------

// File: rtl/scr1_tb_ahb_dmem_monitor_if.sv
// rtl/scr1_tb_ahb_dmem_monitor_if.sv - AHB-Lite dmem bus bundle seen by the monitor
// master/slave modports for the bus ends, monitor modport is input-only.
interface scr1_tb_ahb_dmem_monitor_if #(
   parameter int SCR1_AHB_WIDTH = 32
);
   logic [1:0]                dmem_htrans;
   logic [SCR1_AHB_WIDTH-1:0] dmem_haddr;
   logic                      dmem_hwrite;
   logic [2:0]                dmem_hsize;
   logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata;
   logic                      dmem_hready;
   logic                      dmem_hresp;

   modport master (
      output dmem_htrans, dmem_haddr, dmem_hwrite, dmem_hsize, dmem_hwdata,
      input  dmem_hready, dmem_hresp
   );

   modport slave (
      input  dmem_htrans, dmem_haddr, dmem_hwrite, dmem_hsize, dmem_hwdata,
      output dmem_hready, dmem_hresp
   );

   modport monitor (
      input dmem_htrans, dmem_haddr, dmem_hwrite, dmem_hsize, dmem_hwdata,
            dmem_hready, dmem_hresp
   );
endinterface

// File: rtl/scr1_tb_ahb_dmem_monitor.sv
// rtl/scr1_tb_ahb_dmem_monitor.sv - passive dmem AHB snooper: counters, tohost completion, watchdog
// Optional protocol checker enabled by SCR1_TB_AHB_MON_PROTOCHK_EN.
module scr1_tb_ahb_dmem_monitor #(
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_F000,
   parameter int unsigned WDOG_CYCLES = 2_000_000
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   scr1_tb_ahb_dmem_monitor_if.monitor          dmem,
   output logic                                 test_done,
   output logic                                 test_pass,
   output logic                                 test_timeout,
   output logic [30:0]                          test_code,
   output logic [31:0]                          cycle_cnt,
   output logic [31:0]                          rd_cnt,
   output logic [31:0]                          wr_cnt,
   output logic [31:0]                          err_cnt,
   output logic                                 proto_err
);

   typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_TMO} state_e;

   localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_e      state_q, state_d;
   logic        ap_valid_q, ap_valid_d;
   logic [31:0] ap_addr_q, ap_addr_d;
   logic        ap_write_q, ap_write_d;
   logic [2:0]  ap_size_q, ap_size_d;
   logic        pass_q, pass_d;
   logic [30:0] code_q, code_d;
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [31:0] err_cnt_q, err_cnt_d;
   logic [31:0] wdog_q, wdog_d;

   logic addr_accept;
   logic data_done;
   logic tohost_hit;
   logic wdog_expired;
   logic in_run;

   assign addr_accept  = dmem.dmem_hready && dmem.dmem_htrans[1];
   assign data_done    = ap_valid_q && dmem.dmem_hready;
   assign tohost_hit   = data_done && !dmem.dmem_hresp && ap_write_q
                      && ((ap_addr_q & WORD_MASK) == (TOHOST_ADDR & WORD_MASK))
                      && (ap_size_q == 3'b010) && dmem.dmem_hwdata[0];
   assign wdog_expired = (wdog_q == WDOG_LAST);
   assign in_run       = (state_q == ST_RUN);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state; a completion write wins over a same-cycle watchdog expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (tohost_hit) begin
               state_d = ST_DONE;
            end else if (wdog_expired) begin
               state_d = ST_TMO;
            end
         end
         default: state_d = state_q;
      endcase
   end

   // FSM: outputs
   always_comb begin
      test_done    = (state_q != ST_RUN);
      test_pass    = (state_q == ST_DONE) && pass_q;
      test_timeout = (state_q == ST_TMO);
      test_code    = (state_q == ST_DONE) ? code_q : 31'd0;
   end

   always_comb begin
      ap_valid_d  = ap_valid_q;
      ap_addr_d   = ap_addr_q;
      ap_write_d  = ap_write_q;
      ap_size_d   = ap_size_q;
      pass_d      = pass_q;
      code_d      = code_q;
      cycle_cnt_d = cycle_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      err_cnt_d   = err_cnt_q;
      wdog_d      = wdog_q;

      // Address-phase tracking runs in every state; only accounting is gated by RUN.
      if (dmem.dmem_hready) begin
         ap_valid_d = dmem.dmem_htrans[1];
      end
      if (addr_accept) begin
         ap_addr_d  = dmem.dmem_haddr;
         ap_write_d = dmem.dmem_hwrite;
         ap_size_d  = dmem.dmem_hsize;
      end

      if (in_run) begin
         cycle_cnt_d = sat_inc(cycle_cnt_q);
         wdog_d      = data_done ? 32'd0 : wdog_q + 32'd1;
         if (data_done) begin
            if (dmem.dmem_hresp) begin
               err_cnt_d = sat_inc(err_cnt_q);
            end else if (ap_write_q) begin
               wr_cnt_d = sat_inc(wr_cnt_q);
            end else begin
               rd_cnt_d = sat_inc(rd_cnt_q);
            end
         end
         if (tohost_hit) begin
            pass_d = (dmem.dmem_hwdata == 32'd1);
            code_d = dmem.dmem_hwdata[31:1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ap_valid_q  <= 1'b0;
         ap_addr_q   <= 32'd0;
         ap_write_q  <= 1'b0;
         ap_size_q   <= 3'd0;
         pass_q      <= 1'b0;
         code_q      <= 31'd0;
         cycle_cnt_q <= 32'd0;
         rd_cnt_q    <= 32'd0;
         wr_cnt_q    <= 32'd0;
         err_cnt_q   <= 32'd0;
         wdog_q      <= 32'd0;
      end else begin
         ap_valid_q  <= ap_valid_d;
         ap_addr_q   <= ap_addr_d;
         ap_write_q  <= ap_write_d;
         ap_size_q   <= ap_size_d;
         pass_q      <= pass_d;
         code_q      <= code_d;
         cycle_cnt_q <= cycle_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         err_cnt_q   <= err_cnt_d;
         wdog_q      <= wdog_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign rd_cnt    = rd_cnt_q;
   assign wr_cnt    = wr_cnt_q;
   assign err_cnt   = err_cnt_q;

`ifdef SCR1_TB_AHB_MON_PROTOCHK_EN
   logic        hold_q, hold_d;
   logic [1:0]  hold_trans_q, hold_trans_d;
   logic [31:0] hold_addr_q, hold_addr_d;
   logic        proto_err_q, proto_err_d;
   logic        viol_hold, viol_align, viol_size;

   // A stalled NONSEQ/SEQ must present the same control next cycle.
   always_comb begin
      hold_d       = dmem.dmem_htrans[1] && !dmem.dmem_hready;
      hold_trans_d = dmem.dmem_htrans;
      hold_addr_d  = dmem.dmem_haddr;
      viol_hold    = hold_q && ((dmem.dmem_htrans != hold_trans_q)
                             || (dmem.dmem_haddr != hold_addr_q));
      viol_align   = addr_accept
                  && (((dmem.dmem_hsize == 3'b001) && dmem.dmem_haddr[0])
                   || ((dmem.dmem_hsize == 3'b010) && (dmem.dmem_haddr[1:0] != 2'b00)));
      viol_size    = addr_accept && (dmem.dmem_hsize > 3'b010);
      proto_err_d  = proto_err_q || viol_hold || viol_align || viol_size;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q       <= 1'b0;
         hold_trans_q <= 2'd0;
         hold_addr_q  <= 32'd0;
         proto_err_q  <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_trans_q <= hold_trans_d;
         hold_addr_q  <= hold_addr_d;
         proto_err_q  <= proto_err_d;
         if (viol_hold || viol_align || viol_size) begin
            $error("dmem AHB protocol violation: hold=%0b align=%0b size=%0b addr=%08h",
                   viol_hold, viol_align, viol_size, dmem.dmem_haddr);
         end
      end
   end

   assign proto_err = proto_err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule
